// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: shared types for the accumulator ALU engine.
// Holds the 4-bit opcode enum, the engine FSM states and the bit
// positions of the packed flag register.
package alu_acc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_PASS = 4'd10,
        OP_CMP  = 4'd11,
        OP_MUL  = 4'd12,
        OP_INC  = 4'd13,
        OP_DEC  = 4'd14,
        OP_CLR  = 4'd15
    } op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    // Bit positions inside the packed flag register
    localparam int unsigned FLAG_C    = 0;
    localparam int unsigned FLAG_Z    = 1;
    localparam int unsigned FLAG_N    = 2;
    localparam int unsigned FLAG_V    = 3;
    localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_acc_engine_alu_core.sv
// alu_core: purely combinational WIDTH-bit ALU for every opcode except MUL.
// Ports:
//   op     - operation code
//   a, b   - operands (b ignored by shifts/rotates/NOT/INC/DEC/CLR)
//   result - ALU result
//   carry  - carry/borrow/shifted-out bit, 0 for logic ops
//   ovf    - signed overflow for arithmetic ops, 0 otherwise
module alu_core
    import alu_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // INC/DEC reuse the adder/subtractor with a constant 1 operand
    always_comb begin
        b_arith = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        sum     = {1'b0, a} + {1'b0, b_arith};
        diff    = {1'b0, a} - {1'b0, b_arith};
    end

    // Result and flag selection
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                result = sum[MSB:0];
                carry  = sum[WIDTH];
                ovf    = (a[MSB] == b_arith[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP, OP_DEC: begin
                result = diff[MSB:0];
                carry  = diff[WIDTH];   // borrow: a < b unsigned
                ovf    = (a[MSB] != b_arith[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
            OP_ROL: begin
                result = {a[MSB-1:0], a[MSB]};
                carry  = a[MSB];
            end
            OP_ROR: begin
                result = {a[0], a[MSB:1]};
                carry  = a[0];
            end
            OP_PASS: result = b;
            default: result = '0;   // CLR; MUL is handled by the engine
        endcase
    end

endmodule

// File: rtl/alu_acc_engine.sv
// alu_acc_engine: WIDTH-bit ALU feeding NUM_ACC accumulators, with a
// valid/ready operation handshake, registered flags and a WIDTH-cycle
// shift-add multiplier.
// Ports:
//   clk, clb                       - clock, synchronous active-high reset
//   op_valid/op_ready              - operation handshake
//   op_sel, src_acc, a_idx, dst_idx, in_a, in_b - operation fields
//   res_valid, res_data            - result pulse and held last result
//   carry_out, zero, neg, ovf      - registered flags
//   rd_idx, rd_data                - combinational accumulator read port
module alu_acc_engine
    import alu_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned IDXW    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             clb,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_sel,
    input  logic             src_acc,
    input  logic [IDXW-1:0]  a_idx,
    input  logic [IDXW-1:0]  dst_idx,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             carry_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CNTW = $clog2(WIDTH);

    logic [WIDTH-1:0]     acc_q [NUM_ACC];
    state_e               state_q, state_d;
    logic                 op_ready_q, res_valid_q;
    logic [WIDTH-1:0]     res_data_q;
    logic [NUM_FLAGS-1:0] flags_q;

    logic [PW-1:0]        mcand_q, prod_q, prod_step;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNTW-1:0]      cnt_q;
    logic [IDXW-1:0]      dst_q;

    op_e                  op;
    logic                 xfer, last_step, mul_start;
    logic [WIDTH-1:0]     op_a, alu_res;
    logic                 alu_c, alu_v;

    logic                 wr_en, wr_acc, wr_c, wr_v;
    logic [IDXW-1:0]      wr_idx;
    logic [WIDTH-1:0]     wr_data;

    assign op        = op_e'(op_sel);
    assign xfer      = op_valid && op_ready_q;
    assign mul_start = xfer && (op == OP_MUL);
    assign last_step = (cnt_q == CNTW'(WIDTH - 1));
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign carry_out = flags_q[FLAG_C];
    assign zero      = flags_q[FLAG_Z];
    assign neg       = flags_q[FLAG_N];
    assign ovf       = flags_q[FLAG_V];

    // Operand A and read-port muxes; out-of-range indices read as 0
    always_comb begin
        op_a = in_a;
        if (src_acc) begin
            op_a = '0;
            for (int unsigned i = 0; i < NUM_ACC; i++)
                if (a_idx == IDXW'(i)) op_a = acc_q[i];
        end
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_ACC; i++)
            if (rd_idx == IDXW'(i)) rd_data = acc_q[i];
    end

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op     (op),
        .a      (op_a),
        .b      (in_b),
        .result (alu_res),
        .carry  (alu_c),
        .ovf    (alu_v)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (clb) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and write-back selection
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_acc  = 1'b0;
        wr_idx  = dst_idx;
        wr_data = alu_res;
        wr_c    = alu_c;
        wr_v    = alu_v;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL_RUN;
                end else if (xfer) begin
                    wr_en  = 1'b1;
                    wr_acc = (op != OP_CMP);
                end
            end
            ST_MUL_RUN: begin
                if (last_step) begin
                    state_d = ST_IDLE;
                    wr_en   = 1'b1;
                    wr_acc  = 1'b1;
                    wr_idx  = dst_q;
                    wr_data = prod_step[WIDTH-1:0];
                    wr_c    = |prod_step[PW-1:WIDTH];
                    wr_v    = |prod_step[PW-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, accumulators and multiplier datapath
    always_ff @(posedge clk) begin
        if (clb) begin
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            dst_q       <= '0;
            for (int unsigned i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else begin
            op_ready_q  <= (state_d == ST_IDLE);
            res_valid_q <= wr_en;
            if (wr_en) begin
                res_data_q       <= wr_data;
                flags_q[FLAG_C]  <= wr_c;
                flags_q[FLAG_Z]  <= (wr_data == '0);
                flags_q[FLAG_N]  <= wr_data[WIDTH-1];
                flags_q[FLAG_V]  <= wr_v;
            end
            for (int unsigned i = 0; i < NUM_ACC; i++)
                if (wr_en && wr_acc && (wr_idx == IDXW'(i))) acc_q[i] <= wr_data;

            // Operands are captured at issue so the accumulator may be overwritten
            if ((state_q == ST_IDLE) && mul_start) begin
                mcand_q  <= PW'(op_a);
                mplier_q <= in_b;
                prod_q   <= '0;
                cnt_q    <= '0;
                dst_q    <= dst_idx;
            end else if (state_q == ST_MUL_RUN) begin
                prod_q   <= prod_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_engine.sv
// Directed bench for alu_acc_engine: an 8-bit/4-accumulator instance and a
// 16-bit/8-accumulator instance sharing clock and reset.
module tb_alu_acc_engine;
    import alu_acc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clb;

    // 8-bit instance
    logic        op_valid, op_ready, src_acc, res_valid;
    logic [3:0]  op_sel;
    logic [1:0]  a_idx, dst_idx, rd_idx;
    logic [7:0]  in_a, in_b, res_data, rd_data;
    logic        carry_out, zero, neg, ovf;

    // 16-bit instance
    logic        op_valid_w, op_ready_w, src_acc_w, res_valid_w;
    logic [3:0]  op_sel_w;
    logic [2:0]  a_idx_w, dst_idx_w, rd_idx_w;
    logic [15:0] in_a_w, in_b_w, res_data_w, rd_data_w;
    logic        carry_out_w, zero_w, neg_w, ovf_w;

    int n_cmp = 0;
    int n_bad = 0;

    alu_acc_engine #(.WIDTH(8), .NUM_ACC(4)) u_dut (
        .clk(clk), .clb(clb), .op_valid(op_valid), .op_ready(op_ready),
        .op_sel(op_sel), .src_acc(src_acc), .a_idx(a_idx), .dst_idx(dst_idx),
        .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_data(res_data),
        .carry_out(carry_out), .zero(zero), .neg(neg), .ovf(ovf),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    alu_acc_engine #(.WIDTH(16), .NUM_ACC(8)) u_dut_w (
        .clk(clk), .clb(clb), .op_valid(op_valid_w), .op_ready(op_ready_w),
        .op_sel(op_sel_w), .src_acc(src_acc_w), .a_idx(a_idx_w), .dst_idx(dst_idx_w),
        .in_a(in_a_w), .in_b(in_b_w), .res_valid(res_valid_w), .res_data(res_data_w),
        .carry_out(carry_out_w), .zero(zero_w), .neg(neg_w), .ovf(ovf_w),
        .rd_idx(rd_idx_w), .rd_data(rd_data_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags compared as {carry, zero, neg, ovf}
    task automatic flg(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, carry_out, zero, neg, ovf}, {28'd0, exp});
    endtask

    task automatic flg_w(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, carry_out_w, zero_w, neg_w, ovf_w}, {28'd0, exp});
    endtask

    task automatic rd8(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        rd_idx = idx;
        #1;
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic rd16(input logic [2:0] idx, input logic [15:0] exp, input string tag);
        rd_idx_w = idx;
        #1;
        chk(tag, {16'd0, rd_data_w}, {16'd0, exp});
    endtask

    // Drive one operation, let it transfer, return at the following negedge
    task automatic issue8(input op_e op, input logic src, input logic [1:0] ai,
                          input logic [1:0] dst, input logic [7:0] a, input logic [7:0] b);
        op_sel = op; src_acc = src; a_idx = ai; dst_idx = dst; in_a = a; in_b = b;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic issue16(input op_e op, input logic src, input logic [2:0] ai,
                           input logic [2:0] dst, input logic [15:0] a, input logic [15:0] b);
        op_sel_w = op; src_acc_w = src; a_idx_w = ai; dst_idx_w = dst; in_a_w = a; in_b_w = b;
        op_valid_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid_w = 1'b0;
    endtask

    // After a MUL transfer, check busy for the remaining steps then the result
    task automatic mul8_finish(input string tag, input logic [7:0] exp_res, input logic [3:0] exp_flg);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, "_busy"}, {31'd0, op_ready}, 32'd0);
        end
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
        chk({tag, "_data"}, {24'd0, res_data}, {24'd0, exp_res});
        flg({tag, "_flags"}, exp_flg);
    endtask

    task automatic mul16_finish(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_flg);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, "_busy"}, {31'd0, op_ready_w}, 32'd0);
        end
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid"}, {31'd0, res_valid_w}, 32'd1);
        chk({tag, "_ready"}, {31'd0, op_ready_w}, 32'd1);
        chk({tag, "_data"}, {16'd0, res_data_w}, {16'd0, exp_res});
        flg_w({tag, "_flags"}, exp_flg);
    endtask

    initial begin
        clb = 1'b1;
        op_valid = 1'b0; op_sel = 4'd0; src_acc = 1'b0; a_idx = '0; dst_idx = '0;
        in_a = '0; in_b = '0; rd_idx = '0;
        op_valid_w = 1'b0; op_sel_w = 4'd0; src_acc_w = 1'b0; a_idx_w = '0; dst_idx_w = '0;
        in_a_w = '0; in_b_w = '0; rd_idx_w = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_data", {24'd0, res_data}, 32'd0);
        flg("rst_flags", 4'b0000);
        clb = 1'b0;
        rd8(2'd0, 8'h00, "rst_acc0");

        // ADD with signed overflow
        issue8(OP_ADD, 1'b0, 2'd0, 2'd0, 8'h7F, 8'h01);
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_data", {24'd0, res_data}, 32'h80);
        flg("add_flags", 4'b0011);
        rd8(2'd0, 8'h80, "add_acc0");
        @(negedge clk);
        chk("add_pulse_end", {31'd0, res_valid}, 32'd0);

        // SUB from accumulator with borrow, then CMP without write
        issue8(OP_PASS, 1'b0, 2'd0, 2'd0, 8'h00, 8'h05);
        rd8(2'd0, 8'h05, "pass_acc0");
        issue8(OP_SUB, 1'b1, 2'd0, 2'd1, 8'h00, 8'h06);
        chk("sub_data", {24'd0, res_data}, 32'hFF);
        flg("sub_flags", 4'b1010);
        rd8(2'd1, 8'hFF, "sub_acc1");
        issue8(OP_CMP, 1'b1, 2'd0, 2'd1, 8'h00, 8'h03);
        chk("cmp_valid", {31'd0, res_valid}, 32'd1);
        chk("cmp_data", {24'd0, res_data}, 32'h02);
        flg("cmp_flags", 4'b0000);
        rd8(2'd1, 8'hFF, "cmp_no_write");

        // Back-to-back dependent INC on acc2
        issue8(OP_PASS, 1'b0, 2'd0, 2'd2, 8'h00, 8'hFE);
        op_sel = OP_INC; src_acc = 1'b1; a_idx = 2'd2; dst_idx = 2'd2; op_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("inc1_data", {24'd0, res_data}, 32'hFF);
        chk("inc1_ready", {31'd0, op_ready}, 32'd1);
        flg("inc1_flags", 4'b0010);
        @(posedge clk); @(negedge clk);
        chk("inc2_data", {24'd0, res_data}, 32'h00);
        chk("inc2_valid", {31'd0, res_valid}, 32'd1);
        flg("inc2_flags", 4'b1100);
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0;
        chk("inc3_data", {24'd0, res_data}, 32'h01);
        flg("inc3_flags", 4'b0000);
        rd8(2'd2, 8'h01, "inc_acc2");

        // MUL 0x10 x 0x20 with op_valid held during busy
        op_sel = OP_MUL; src_acc = 1'b0; dst_idx = 2'd3; in_a = 8'h10; in_b = 8'h20;
        op_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mul_busy0", {31'd0, op_ready}, 32'd0);
        chk("mul_novalid0", {31'd0, res_valid}, 32'd0);
        op_sel = OP_ADD; dst_idx = 2'd0; in_a = 8'h01; in_b = 8'h01;
        mul8_finish("mul_hi", 8'h00, 4'b1101);
        op_valid = 1'b0;
        rd8(2'd3, 8'h00, "mul_hi_acc3");
        rd8(2'd0, 8'h05, "mul_held_ignored");
        @(negedge clk);
        chk("mul_pulse_end", {31'd0, res_valid}, 32'd0);

        // MUL without high-half bits
        issue8(OP_MUL, 1'b0, 2'd0, 2'd3, 8'h0D, 8'h0B);
        mul8_finish("mul_lo", 8'h8F, 4'b0010);
        rd8(2'd3, 8'h8F, "mul_lo_acc3");

        // Reset during MUL aborts it
        issue8(OP_MUL, 1'b0, 2'd0, 2'd1, 8'h03, 8'h05);
        @(posedge clk); @(negedge clk);
        clb = 1'b1;
        @(posedge clk); @(negedge clk);
        clb = 1'b0;
        chk("abort_ready", {31'd0, op_ready}, 32'd1);
        chk("abort_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_data", {24'd0, res_data}, 32'd0);
        flg("abort_flags", 4'b0000);
        rd8(2'd0, 8'h00, "abort_acc0");
        rd8(2'd1, 8'h00, "abort_acc1");
        rd8(2'd2, 8'h00, "abort_acc2");
        rd8(2'd3, 8'h00, "abort_acc3");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_pulse", {31'd0, res_valid}, 32'd0);
        end
        rd8(2'd1, 8'h00, "abort_no_write");

        // Shifts, rotates and logic ops
        issue8(OP_ROL, 1'b0, 2'd0, 2'd0, 8'h81, 8'h00);
        chk("rol_data", {24'd0, res_data}, 32'h03);
        flg("rol_flags", 4'b1000);
        issue8(OP_SHR, 1'b0, 2'd0, 2'd1, 8'h01, 8'h00);
        chk("shr_data", {24'd0, res_data}, 32'h00);
        flg("shr_flags", 4'b1100);
        issue8(OP_ROR, 1'b0, 2'd0, 2'd2, 8'h01, 8'h00);
        chk("ror_data", {24'd0, res_data}, 32'h80);
        flg("ror_flags", 4'b1010);
        issue8(OP_SHL, 1'b0, 2'd0, 2'd3, 8'hC0, 8'h00);
        chk("shl_data", {24'd0, res_data}, 32'h80);
        flg("shl_flags", 4'b1010);
        issue8(OP_XOR, 1'b0, 2'd0, 2'd3, 8'hF0, 8'hFF);
        chk("xor_data", {24'd0, res_data}, 32'h0F);
        issue8(OP_AND, 1'b0, 2'd0, 2'd3, 8'hF0, 8'h3C);
        chk("and_data", {24'd0, res_data}, 32'h30);
        issue8(OP_OR, 1'b0, 2'd0, 2'd3, 8'h50, 8'h0A);
        chk("or_data", {24'd0, res_data}, 32'h5A);
        issue8(OP_NOT, 1'b1, 2'd3, 2'd3, 8'h00, 8'h00);
        chk("not_data", {24'd0, res_data}, 32'hA5);
        flg("not_flags", 4'b0010);
        issue8(OP_DEC, 1'b1, 2'd2, 2'd2, 8'h00, 8'h00);
        chk("dec_data", {24'd0, res_data}, 32'h7F);
        flg("dec_flags", 4'b0001);
        issue8(OP_CLR, 1'b0, 2'd0, 2'd0, 8'h12, 8'h34);
        chk("clr_data", {24'd0, res_data}, 32'h00);
        flg("clr_flags", 4'b0100);
        rd8(2'd0, 8'h00, "clr_acc0");
        rd8(2'd1, 8'h00, "shr_acc1");
        rd8(2'd2, 8'h7F, "dec_acc2");

        // 16-bit, 8-accumulator instance
        issue16(OP_ADD, 1'b0, 3'd0, 3'd7, 16'h7FFF, 16'h0001);
        chk("w_add_data", {16'd0, res_data_w}, 32'h8000);
        flg_w("w_add_flags", 4'b0011);
        rd16(3'd7, 16'h8000, "w_add_acc7");
        issue16(OP_MUL, 1'b1, 3'd7, 3'd5, 16'h0000, 16'h0002);
        chk("w_mul_busy0", {31'd0, op_ready_w}, 32'd0);
        mul16_finish("w_mul_hi", 16'h0000, 4'b1101);
        issue16(OP_MUL, 1'b0, 3'd0, 3'd6, 16'h00FF, 16'h0101);
        mul16_finish("w_mul_lo", 16'hFFFF, 4'b0010);
        rd16(3'd6, 16'hFFFF, "w_mul_acc6");
        issue16(OP_SHR, 1'b0, 3'd0, 3'd1, 16'h0001, 16'h0000);
        chk("w_shr_data", {16'd0, res_data_w}, 32'h0000);
        flg_w("w_shr_flags", 4'b1100);
        issue16(OP_ROL, 1'b0, 3'd0, 3'd2, 16'h8001, 16'h0000);
        chk("w_rol_data", {16'd0, res_data_w}, 32'h0003);
        flg_w("w_rol_flags", 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
